// File: rtl/tone_meter.sv
// Period meter for a square-wave input: reports period, half-period divider,
// a one-cycle update strobe, a silence flag and a frequency-lock flag.
module tone_meter #(
  parameter int CNT_W      = 20,
  parameter int MIN_PERIOD = 1000,
  parameter int TIMEOUT    = 1048575,
  parameter int LOCK_TOL   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-2:0] half_div,
  output logic             period_valid,
  output logic             silent,
  output logic             locked
);

  localparam logic [0:0] ST_SILENT = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam int         DW        = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam logic [DW-1:0]    TOL_C   = DW'(LOCK_TOL);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [2:0]       sync_q;
  logic             rise;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-2:0] half_q, half_d;
  logic             valid_q, valid_d;
  logic             silent_q, silent_d;
  logic             locked_q, locked_d;
  logic             have_prev_q, have_prev_d;
  logic [DW-1:0]    cur_w, old_w, diff;

  // Two synchronizer flops plus one history flop for rising-edge detection
  assign rise = sync_q[1] & ~sync_q[2];

  assign cur_w = {1'b0, cnt_q};
  assign old_w = {1'b0, period_q};
  assign diff  = (cur_w >= old_w) ? (cur_w - old_w) : (old_w - cur_w);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    half_d      = half_q;
    valid_d     = 1'b0;
    silent_d    = silent_q;
    locked_d    = locked_q;
    have_prev_d = have_prev_q;
    case (state_q)
      ST_SILENT: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_RUN;
          cnt_d   = ONE;
        end
      end
      default: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Timeout takes priority; a coincident edge still arms a new measurement
        if (cnt_q == TO_C) begin
          period_d    = '0;
          half_d      = '0;
          silent_d    = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
          if (rise) begin
            cnt_d = ONE;
          end else begin
            state_d = ST_SILENT;
            cnt_d   = '0;
          end
        end else if (rise && (cnt_q >= MIN_C)) begin
          period_d    = cnt_q;
          half_d      = cnt_q[CNT_W-1:1];
          valid_d     = 1'b1;
          cnt_d       = ONE;
          silent_d    = 1'b0;
          locked_d    = have_prev_q && (diff <= TOL_C);
          have_prev_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= ST_SILENT;
      cnt_q       <= '0;
      period_q    <= '0;
      half_q      <= '0;
      valid_q     <= 1'b0;
      silent_q    <= 1'b1;
      locked_q    <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[1:0], tone_in};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      half_q      <= half_d;
      valid_q     <= valid_d;
      silent_q    <= silent_d;
      locked_q    <= locked_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign period       = period_q;
  assign half_div     = half_q;
  assign period_valid = valid_q;
  assign silent       = silent_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_tone_meter.sv
// Bench for tone_meter: timestamp-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_tone_meter;
  localparam int CW   = 16;
  localparam int MINP = 100;
  localparam int TO   = 3000;
  localparam int TOL  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tone_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-2:0] half_div;
  logic          period_valid, silent, locked;

  tone_meter #(.CNT_W(CW), .MIN_PERIOD(MINP), .TIMEOUT(TO), .LOCK_TOL(TOL)) dut (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_in), .period(period),
    .half_div(half_div), .period_valid(period_valid), .silent(silent), .locked(locked));

  always #5 clk = ~clk;

  // Model state: measurement timestamps rather than a running counter
  typedef struct packed {
    logic run; int tlast; int per; logic sil; logic lck; logic hp; logic vld;
  } mdl_t;

  mdl_t m;
  int   cyc;
  logic [2:0] smp;

  function automatic mdl_t step(mdl_t c, logic r, int now);
    mdl_t n;
    int el, d;
    n = c;
    n.vld = 1'b0;
    if (c.run) begin
      el = now - c.tlast;
      if (el == TO) begin
        n.per = 0; n.sil = 1'b1; n.lck = 1'b0; n.hp = 1'b0;
        if (r) n.tlast = now;
        else n.run = 1'b0;
      end else if (r && el >= MINP) begin
        d = el - c.per;
        if (d < 0) d = -d;
        n.lck = c.hp && (d <= TOL);
        n.per = el; n.vld = 1'b1; n.tlast = now; n.sil = 1'b0; n.hp = 1'b1;
      end
    end else if (r) begin
      n.run = 1'b1;
      n.tlast = now;
    end
    return n;
  endfunction

  // A rise of tone_in sampled two clocks ago is acted on at this clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '{run: 1'b0, tlast: 0, per: 0, sil: 1'b1, lck: 1'b0, hp: 1'b0, vld: 1'b0};
      smp <= '0;
      cyc <= 0;
    end else begin
      m   <= step(m, smp[1] & ~smp[2], cyc);
      smp <= {smp[1:0], tone_in};
      cyc <= cyc + 1;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int tk = 0, vld_at = 0, rise_at = 0, nv = 0, nv0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at tick %0d: got %0d, expected %0d", name, tk, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tk++;
    if (period_valid) begin vld_at = tk; nv++; end
    chk("period", int'(period), m.per);
    chk("half_div", int'(half_div), m.per >> 1);
    chk("period_valid", int'(period_valid), int'(m.vld));
    chk("silent", int'(silent), int'(m.sil));
    chk("locked", int'(locked), int'(m.lck));
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      tone_in = 1'b1; rise_at = tk;
      repeat (hi) tick();
      tone_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    // Reset held while the input toggles
    for (int i = 0; i < 8; i++) begin tone_in = ~tone_in; tick(); end
    chk("rst_period", int'(period), 0);
    chk("rst_silent", int'(silent), 1);
    chk("rst_locked", int'(locked), 0);
    tone_in = 1'b0; tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // 568-cycle tone: first rise arms, second measures
    nv0 = nv;
    wave(284, 284, 2);
    chk("first_nvalid", nv - nv0, 1);
    chk("first_period", int'(period), 568);
    chk("first_half", int'(half_div), 284);
    chk("model_period", m.per, 568);
    chk("first_silent", int'(silent), 0);
    chk("first_locked", int'(locked), 0);
    chk("valid_latency", vld_at - rise_at, 3);
    wave(284, 284, 1);
    chk("third_locked", int'(locked), 1);

    // Glitch 35 cycles after an accepted edge is rejected
    tone_in = 1'b1; repeat (30) tick();
    tone_in = 1'b0; repeat (5) tick();
    tone_in = 1'b1; repeat (10) tick();
    tone_in = 1'b0; repeat (523) tick();
    wave(284, 284, 1);
    chk("glitch_period", int'(period), 568);
    chk("glitch_locked", int'(locked), 1);

    // Frequency step to 284 cycles
    wave(142, 142, 1);
    chk("step_period", int'(period), 568);
    wave(142, 142, 1);
    chk("step_period2", int'(period), 284);
    chk("step_locked", int'(locked), 0);
    wave(146, 146, 1);
    chk("step_relock", int'(locked), 1);
    // 284 -> 292 is exactly at tolerance
    wave(146, 147, 1);
    chk("tol_period", int'(period), 292);
    chk("tol_locked", int'(locked), 1);
    wave(50, 50, 1);
    chk("tol_period2", int'(period), 293);
    // Exactly MIN_PERIOD is accepted, one below is not
    wave(49, 50, 2);
    chk("min_period", int'(period), 100);
    chk("min_locked", int'(locked), 0);
    wave(200, 200, 1);
    chk("reject_99", int'(period), 198);

    // Silence after the last accepted edge
    for (int i = 0; i < 4000 && !silent; i++) tick();
    chk("timeout_reached", int'(silent), 1);
    chk("timeout_cycles", tk - vld_at, TO);
    chk("timeout_period", int'(period), 0);
    chk("timeout_locked", int'(locked), 0);

    // Re-arm, then edges landing exactly on the timeout only re-arm
    nv0 = nv;
    wave(1500, 1500, 2);
    wave(1500, 1499, 1);
    chk("collide_nvalid", nv - nv0, 0);
    chk("collide_silent", int'(silent), 1);
    chk("collide_period", int'(period), 0);
    wave(284, 284, 1);
    chk("after_collide_period", int'(period), 2999);
    chk("after_collide_silent", int'(silent), 0);
    chk("after_collide_locked", int'(locked), 0);
    wave(284, 284, 2);
    chk("relock_period", int'(period), 568);
    chk("relock_locked", int'(locked), 1);

    // Asynchronous reset partway through a period
    tone_in = 1'b1;
    repeat (100) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_period", int'(period), 0);
    chk("arst_half", int'(half_div), 0);
    chk("arst_valid", int'(period_valid), 0);
    chk("arst_silent", int'(silent), 1);
    chk("arst_locked", int'(locked), 0);
    tone_in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    nv0 = nv;
    wave(284, 284, 2);
    chk("post_rst_nvalid", nv - nv0, 1);
    chk("post_rst_period", int'(period), 568);
    chk("post_rst_locked", int'(locked), 0);
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
